// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: frame sequencer for two banks of serial ADCs (pot and current).
// One FSM drives both banks. Each frame holds conv high, clocks out 16 bits
// MSB-first on sclk, then spends one cycle adding the words to per-axis
// accumulators. After 2^AVG_LOG2 contributing frames the averaged words are
// registered and the matching ready signal pulses. The pot bank only takes
// part in every POT_DECIM-th frame.
//
// Ports:
//   clkadc    - sole clock, rising edge
//   reset     - asynchronous, active-low
//   enable    - run frames back-to-back while high; finish current frame when low
//   sclk[1:2] - serial clocks, [1] pot bank, [2] current bank (idle low)
//   conv[1:2] - convert strobes, [1] pot bank, [2] current bank
//   miso      - [NUM_AXES-1:0] pot axes, upper NUM_AXES bits current axes
//   cur/pot   - averaged words, axis n at [16n+15:16n]
//   cur_ready - one-cycle pulse when cur updates
//   pot_ready - one-cycle pulse when pot updates
//   frame_cnt - completed-frame counter, wraps
module adc_scan_ctrl #(
  parameter int unsigned NUM_AXES  = 4,
  parameter int unsigned SCLK_HALF = 2,
  parameter int unsigned CONV_CYC  = 160,
  parameter int unsigned AVG_LOG2  = 0,
  parameter int unsigned POT_DECIM = 1
) (
  input  logic                    clkadc,
  input  logic                    reset,
  input  logic                    enable,
  output logic [1:2]              sclk,
  output logic [1:2]              conv,
  input  logic [2*NUM_AXES-1:0]   miso,
  output logic [16*NUM_AXES-1:0]  cur,
  output logic                    cur_ready,
  output logic [16*NUM_AXES-1:0]  pot,
  output logic                    pot_ready,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned AccW  = 16 + AVG_LOG2;
  localparam int unsigned ConvW = $clog2(CONV_CYC);
  localparam int unsigned HalfW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int unsigned DecW  = (POT_DECIM > 1) ? $clog2(POT_DECIM) : 1;
  localparam int unsigned AvgW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [ConvW-1:0] ConvLast = ConvW'(CONV_CYC - 1);
  localparam logic [HalfW-1:0] HalfLast = HalfW'(SCLK_HALF - 1);
  localparam logic [DecW-1:0]  DecLast  = DecW'(POT_DECIM - 1);
  localparam logic [AvgW-1:0]  AvgLast  = AvgW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {StIdle, StConv, StShift, StAcc} state_e;

  state_e state_q, state_d;

  // Sequencing counters: conv length, position inside an sclk half period,
  // and index of the half period (0..31) within the shift phase.
  logic [ConvW-1:0] conv_cnt_q, conv_cnt_d;
  logic [HalfW-1:0] half_cnt_q, half_cnt_d;
  logic [4:0]       half_idx_q, half_idx_d;

  logic [DecW-1:0] dec_q;
  logic [AvgW-1:0] cur_cnt_q;
  logic [AvgW-1:0] pot_cnt_q;

  logic [NUM_AXES-1:0][15:0]     cur_sr_q;
  logic [NUM_AXES-1:0][15:0]     pot_sr_q;
  logic [NUM_AXES-1:0][AccW-1:0] cur_acc_q;
  logic [NUM_AXES-1:0][AccW-1:0] pot_acc_q;
  logic [NUM_AXES-1:0][AccW-1:0] cur_sum;
  logic [NUM_AXES-1:0][AccW-1:0] pot_sum;
  logic [NUM_AXES-1:0][15:0]     cur_q;
  logic [NUM_AXES-1:0][15:0]     pot_q;

  logic        cur_ready_q;
  logic        pot_ready_q;
  logic [15:0] frame_q;

  logic pot_frame;
  logic conv_done;
  logic shift_done;
  logic sclk_high;
  logic sample;
  logic cur_done;
  logic pot_done;

  // Decimation counter at zero marks a frame in which the pot bank runs.
  assign pot_frame  = (dec_q == '0);
  assign conv_done  = (state_q == StConv) && (conv_cnt_q == ConvLast);
  assign shift_done = (state_q == StShift) && (half_idx_q == 5'd31) && (half_cnt_q == HalfLast);
  // Odd half periods are the high phases of sclk.
  assign sclk_high  = (state_q == StShift) && half_idx_q[0];
  // The first cycle of each high phase is the cycle in which sclk rises.
  assign sample     = sclk_high && (half_cnt_q == '0);
  assign cur_done   = (cur_cnt_q == AvgLast);
  assign pot_done   = (pot_cnt_q == AvgLast);

  always_comb begin
    conv[2] = (state_q == StConv);
    conv[1] = (state_q == StConv) && pot_frame;
    sclk[2] = sclk_high;
    sclk[1] = sclk_high && pot_frame;
  end

  assign cur       = cur_q;
  assign pot       = pot_q;
  assign cur_ready = cur_ready_q;
  assign pot_ready = pot_ready_q;
  assign frame_cnt = frame_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StConv;
      StConv:  if (conv_done) state_d = StShift;
      StShift: if (shift_done) state_d = StAcc;
      StAcc:   state_d = enable ? StConv : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Phase counters; they rest at zero outside their own state.
  always_comb begin
    conv_cnt_d = '0;
    half_cnt_d = '0;
    half_idx_d = '0;
    if ((state_q == StConv) && !conv_done) begin
      conv_cnt_d = conv_cnt_q + ConvW'(1);
    end
    if (state_q == StShift) begin
      if (half_cnt_q == HalfLast) begin
        half_cnt_d = '0;
        half_idx_d = half_idx_q + 5'd1;
      end else begin
        half_cnt_d = half_cnt_q + HalfW'(1);
        half_idx_d = half_idx_q;
      end
    end
  end

  // Accumulator plus the word just shifted in; sized so 2^AVG_LOG2 words cannot overflow.
  always_comb begin
    for (int n = 0; n < int'(NUM_AXES); n++) begin
      cur_sum[n] = cur_acc_q[n] + AccW'(cur_sr_q[n]);
      pot_sum[n] = pot_acc_q[n] + AccW'(pot_sr_q[n]);
    end
  end

  always_ff @(posedge clkadc or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      conv_cnt_q <= '0;
      half_cnt_q <= '0;
      half_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      half_cnt_q <= half_cnt_d;
      half_idx_q <= half_idx_d;
    end
  end

  always_ff @(posedge clkadc or negedge reset) begin
    if (!reset) begin
      dec_q       <= '0;
      cur_cnt_q   <= '0;
      pot_cnt_q   <= '0;
      cur_sr_q    <= '0;
      pot_sr_q    <= '0;
      cur_acc_q   <= '0;
      pot_acc_q   <= '0;
      cur_q       <= '0;
      pot_q       <= '0;
      cur_ready_q <= 1'b0;
      pot_ready_q <= 1'b0;
      frame_q     <= '0;
    end else begin
      cur_ready_q <= 1'b0;
      pot_ready_q <= 1'b0;

      if (sample) begin
        for (int n = 0; n < int'(NUM_AXES); n++) begin
          cur_sr_q[n] <= {cur_sr_q[n][14:0], miso[NUM_AXES + n]};
          // Pot shifters stay frozen on frames where the pot bank is not clocked.
          if (pot_frame) begin
            pot_sr_q[n] <= {pot_sr_q[n][14:0], miso[n]};
          end
        end
      end

      if (state_q == StAcc) begin
        frame_q     <= frame_q + 16'd1;
        dec_q       <= (dec_q == DecLast) ? '0 : dec_q + DecW'(1);

        cur_cnt_q   <= cur_done ? '0 : cur_cnt_q + AvgW'(1);
        cur_ready_q <= cur_done;
        for (int n = 0; n < int'(NUM_AXES); n++) begin
          if (cur_done) begin
            cur_q[n]     <= cur_sum[n][AccW-1:AVG_LOG2];
            cur_acc_q[n] <= '0;
          end else begin
            cur_acc_q[n] <= cur_sum[n];
          end
        end

        if (pot_frame) begin
          pot_cnt_q   <= pot_done ? '0 : pot_cnt_q + AvgW'(1);
          pot_ready_q <= pot_done;
          for (int n = 0; n < int'(NUM_AXES); n++) begin
            if (pot_done) begin
              pot_q[n]     <= pot_sum[n][AccW-1:AVG_LOG2];
              pot_acc_q[n] <= '0;
            end else begin
              pot_acc_q[n] <= pot_sum[n];
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 Parameter NUM_AXES, default 4, axes per bank (1..8).
REQ-002 Parameter SCLK_HALF, default 2, clkadc cycles per sclk half-period (>=1).
REQ-003 Parameter CONV_CYC, default 160, clkadc cycles conv is held high per frame (>=2).
REQ-004 Parameter AVG_LOG2, default 0, log2 of frames averaged per output (0..4).
REQ-005 Parameter POT_DECIM, default 1, pot bank sampled once per POT_DECIM frames (1..256).
REQ-006 clkadc  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-low.
REQ-008 enable  in  1  high: run frames back-to-back; low: finish current frame, then idle.
REQ-009 sclk  out  [1:2]  serial clock; [1] pot bank, [2] current bank.
REQ-010 conv  out  [1:2]  convert strobe; [1] pot bank, [2] current bank.
REQ-011 miso  in  2*NUM_AXES  bits [NUM_AXES-1:0] pot axes, upper NUM_AXES bits current axes.
REQ-012 cur  out  16*NUM_AXES  averaged current words, axis n at [16n+15:16n].
REQ-013 cur_ready  out  1  one-cycle pulse, new cur data.
REQ-014 pot  out  16*NUM_AXES  averaged pot words, same packing.
REQ-015 pot_ready  out  1  one-cycle pulse, new pot data.
REQ-016 frame_cnt  out  16  completed-frame counter, wraps 0xFFFF->0.

Function
REQ-017 FSM states IDLE, CONV, SHIFT, ACC; single sequencer drives both banks.
REQ-018 IDLE->CONV when enable=1; stay IDLE otherwise.
REQ-019 CONV: conv[2]=1 for exactly CONV_CYC cycles, conv[1]=1 only on pot frames; then SHIFT.
REQ-020 SHIFT: conv=0; 16 sclk periods, each SCLK_HALF cycles low then SCLK_HALF high; sclk idle low.
REQ-021 Each miso bit sampled on the cycle sclk rises, MSB first; 16 bits per axis.
REQ-022 sclk[1] toggles only on pot frames; held 0 otherwise.
REQ-023 ACC (1 cycle): add each shifted word to per-axis accumulator of width 16+AVG_LOG2; frame_cnt+1; then CONV if enable=1 else IDLE.
REQ-024 Frame length = CONV_CYC + 32*SCLK_HALF + 1 cycles; no gap between frames while enable=1.
REQ-025 Pot frame = frame whose decimation counter is 0; counter 0..POT_DECIM-1, advances in ACC, wraps to 0.
REQ-026 Current accumulator completes after 2^AVG_LOG2 current frames; pot after 2^AVG_LOG2 pot frames.
REQ-027 On completion, output word = (accumulator incl. current sample) >> AVG_LOG2, truncated; accumulator cleared; ready pulses same cycle output registers update (cycle after ACC).
REQ-028 cur/pot hold last value between updates.
REQ-029 cur_ready and pot_ready may pulse in the same cycle.
REQ-030 enable deasserted mid-frame: frame completes normally; partial accumulation and decimation counter retained and resumed on re-enable.
REQ-031 enable toggled in ACC cycle: sampled value at ACC decides CONV vs IDLE.

Reset
REQ-032 reset low asynchronously forces: state IDLE, conv=0, sclk=0, cur=0, pot=0, cur_ready=0, pot_ready=0, frame_cnt=0, accumulators, shift registers and decimation counter=0.
REQ-033 reset mid-frame aborts frame; no ready pulse for it; first frame after release starts from IDLE with pot frame.

Verification
REQ-034 Defaults, enable=1, ADC models return axis n pot 0x1000+n, cur 0x8000+n -> conv high 160 cycles, 16 sclk pulses period 4, cur_ready and pot_ready every 225 cycles, cur=0x8003_8002_8001_8000, pot=0x1003_1002_1001_1000.
REQ-035 AVG_LOG2=2, cur axis0 returns 10,11,12,14 over 4 frames -> single cur_ready after 4th frame, axis0=11 (47>>2).
REQ-036 POT_DECIM=3 -> conv[1]/sclk[1] active frames 0,3,6; pot_ready every 3rd frame, cur_ready every frame.
REQ-037 enable dropped during SHIFT of frame 5 -> frame 5 completes, ready pulses, FSM IDLE, sclk/conv stay 0; re-enable resumes with frame_cnt=6.
REQ-038 reset asserted mid-SHIFT -> conv, sclk, outputs 0 same cycle, no ready pulse; frame_cnt 0xFFFF increment test wraps to 0.
